dmem_responder: RTL



---
 rtl/dmem_responder.sv | 113 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: latency-programmable line-wide memory responder for dcache fills/write-backs.
// Optional protocol checker enabled with `define DMEM_PROTOCOL_CHECK_EN.
module dmem_responder #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 512,
  parameter int OFFS_W  = 5,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam bit FAST  = (LATENCY == 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    TURN
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_q;
  logic [LINE_W-1:0] dat_q;
  logic [LINE_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  a_idx;
  logic              acc;
  logic              fire;
  logic [IDX_W-1:0]  c_idx;
  logic              c_wr;
  logic [LINE_W-1:0] c_dat;
  logic              unused_ok;

  assign a_idx = addr_i[OFFS_W+IDX_W-1:OFFS_W];
  assign unused_ok = ^{addr_i[ADDR_W-1:OFFS_W+IDX_W],
                       addr_i[OFFS_W-1:0]};

  assign acc = (state_q == IDLE) && enable_i;

  // With single-cycle latency the commit uses the live request.
  assign fire  = rst_i && (FAST ? acc
                               : (state_q == WAIT && cnt_q == 8'd0));
  assign c_idx = FAST ? a_idx   : idx_q;
  assign c_wr  = FAST ? write_i : wr_q;
  assign c_dat = FAST ? data_i  : dat_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable_i) state_d = FAST ? ACK : WAIT;
      WAIT: if (cnt_q == 8'd0) state_d = ACK;
      ACK:  state_d = TURN;
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      dat_q   <= '0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      state_q <= state_d;
      ack_o   <= fire;
      if (acc) begin
        idx_q <= a_idx;
        wr_q  <= write_i;
        dat_q <= data_i;
        cnt_q <= 8'(LATENCY - 1);
      end else if (state_q == WAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (fire && !c_wr) data_o <= mem[c_idx];
    end
  end

  // Array is never reset so preloaded contents survive.
  always_ff @(posedge clk_i) begin
    if (fire && c_wr) mem[c_idx] <= c_dat;
  end

`ifdef DMEM_PROTOCOL_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if (state_q == WAIT &&
                 (!enable_i || a_idx != idx_q || write_i != wr_q)) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule
